// File: rtl/batch_mult_engine.sv
// Memory-mapped batch multiplier: loads operand pairs big-endian from byte memory,
// multiplies by radix-2 shift-add on magnitudes, and stores the products MSB first.
module batch_mult_engine #(
    parameter int OP_BYTES  = 2,
    parameter int NUM_PAIRS = 16,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 64,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              signed_mode,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done
);
    localparam int W     = 8 * OP_BYTES;
    localparam int NB    = 2 * OP_BYTES;
    localparam int CNT_W = $clog2(W) + 1;
    localparam int J_W   = $clog2(NUM_PAIRS + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_STORE, S_NEXT, S_DONE} state_t;

    state_t           state, state_next;
    logic [J_W-1:0]   j;
    logic [CNT_W-1:0] cnt;
    logic [2*W-9:0]   ab_sh;
    logic [2*W-1:0]   ab_next;
    logic [W-1:0]     a_mag;
    logic [2*W:0]     acc, acc_step;
    logic [W:0]       sum;
    logic [2*W-1:0]   prod;
    logic             neg, smode;
    logic [31:0]      offset;

    function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
        return (s && v[W-1]) ? -v : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Any start=1 while a run is active aborts straight back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!start) state_next = S_LOAD;
            S_LOAD:  if (start) state_next = S_IDLE;
                     else if (cnt == CNT_W'(NB - 1)) state_next = S_MUL;
            S_MUL:   if (start) state_next = S_IDLE;
                     else if (cnt == CNT_W'(W - 1)) state_next = S_STORE;
            S_STORE: if (start) state_next = S_IDLE;
                     else if (cnt == CNT_W'(NB - 1)) state_next = S_NEXT;
            S_NEXT:  if (start) state_next = S_IDLE;
                     else if (j == J_W'(NUM_PAIRS - 1)) state_next = S_DONE;
                     else state_next = S_LOAD;
            S_DONE:  if (start) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // acc = {upper W+1 bits, multiplier bits}; add then shift right each step.
    always_comb begin
        ab_next  = {ab_sh, mem_rdata};
        sum      = acc[2*W:W] + (acc[0] ? {1'b0, a_mag} : '0);
        acc_step = {1'b0, sum, acc[W-1:1]};
        offset   = 32'(j) * 32'(NB) + 32'(cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j     <= '0;
            cnt   <= '0;
            ab_sh <= '0;
            a_mag <= '0;
            acc   <= '0;
            prod  <= '0;
            neg   <= 1'b0;
            smode <= 1'b0;
        end else begin
            if (state_next == state && state != S_IDLE && state != S_DONE)
                cnt <= cnt + CNT_W'(1);
            else
                cnt <= '0;
            case (state)
                S_IDLE: if (!start) begin
                    smode <= signed_mode;
                    j     <= '0;
                end
                S_LOAD: begin
                    ab_sh <= ab_next[2*W-9:0];
                    if (cnt == CNT_W'(NB - 1)) begin
                        a_mag <= mag(ab_next[2*W-1:W], smode);
                        acc   <= {{(W+1){1'b0}}, mag(ab_next[W-1:0], smode)};
                        neg   <= smode & (ab_next[2*W-1] ^ ab_next[W-1]);
                    end
                end
                S_MUL: begin
                    acc <= acc_step;
                    if (cnt == CNT_W'(W - 1))
                        prod <= neg ? -acc_step[2*W-1:0] : acc_step[2*W-1:0];
                end
                S_STORE: prod <= prod << 8;
                S_NEXT:  j <= j + J_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr_en = 1'b0;
        busy      = (state != S_IDLE) && (state != S_DONE);
        done      = (state == S_DONE);
        case (state)
            S_LOAD:  mem_addr = ADDR_W'(32'(SRC_BASE) + offset);
            S_STORE: begin
                mem_addr  = ADDR_W'(32'(DST_BASE) + offset);
                mem_wdata = prod[2*W-1 -: 8];
                mem_wr_en = !start;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_batch_mult_engine.sv
// Bench for batch_mult_engine: default instance checked through a write scoreboard and
// a vector table; a small OP_BYTES=1 instance checks the narrow configuration.
module tb_batch_mult_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start0, sm0, start1, sm1;
    logic [7:0] addr0, rdata0, wdata0, addr1, rdata1, wdata1;
    logic       wr0, busy0, done0, wr1, busy1, done1;
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic       f0_en, f1_en;
    logic [7:0] f0_addr, f0_data, f1_addr, f1_data;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] p;
    } vec_t;
    vec_t tv[8];
    int   tv_pair[8];

    logic [15:0] a_v[16];
    logic [15:0] b_v[16];
    logic [31:0] p_v[16];

    batch_mult_engine u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .signed_mode(sm0),
        .mem_addr(addr0), .mem_rdata(rdata0), .mem_wr_en(wr0), .mem_wdata(wdata0),
        .busy(busy0), .done(done0)
    );

    batch_mult_engine #(.OP_BYTES(1), .NUM_PAIRS(2), .SRC_BASE(0), .DST_BASE(4), .ADDR_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(sm1),
        .mem_addr(addr1), .mem_rdata(rdata1), .mem_wr_en(wr1), .mem_wdata(wdata1),
        .busy(busy1), .done(done1)
    );

    assign rdata0 = mem0[addr0];
    assign rdata1 = mem1[addr1];

    always @(posedge clk) begin
        if (wr0) mem0[addr0] <= wdata0;
        else if (f0_en) mem0[f0_addr] <= f0_data;
        if (wr1) mem1[addr1] <= wdata1;
        else if (f1_en) mem1[f1_addr] <= f1_data;
    end

    // Scoreboard: every DUT write must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (wr0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr=%02h data=%02h, none expected", addr0, wdata0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({addr0, wdata0} !== e) begin
                    errors++;
                    $display("FAIL wr_byte: got addr=%02h data=%02h, expected addr=%02h data=%02h",
                             addr0, wdata0, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, got, want);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic signed [31:0] sa, sb;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        if (s) return sa * sb;
        return {16'b0, a} * {16'b0, b};
    endfunction

    task automatic wr_mem0(input int addr, input logic [7:0] data);
        @(negedge clk);
        f0_en = 1'b1; f0_addr = 8'(addr); f0_data = data;
        @(posedge clk);
        #1 f0_en = 1'b0;
    endtask

    task automatic wr_mem1(input int addr, input logic [7:0] data);
        @(negedge clk);
        f1_en = 1'b1; f1_addr = 8'(addr); f1_data = data;
        @(posedge clk);
        #1 f1_en = 1'b0;
    endtask

    task automatic fill_src0();
        for (int p = 0; p < 16; p++) begin
            wr_mem0(4*p,     a_v[p][15:8]);
            wr_mem0(4*p + 1, a_v[p][7:0]);
            wr_mem0(4*p + 2, b_v[p][15:8]);
            wr_mem0(4*p + 3, b_v[p][7:0]);
        end
    endtask

    task automatic clear_dst0();
        for (int k = 64; k < 128; k++) wr_mem0(k, 8'hA5);
    endtask

    task automatic push_pair(input int p, input int nbytes);
        logic [31:0] v;
        v = p_v[p];
        for (int k = 0; k < nbytes; k++) begin
            exp_q.push_back({8'(64 + 4*p + k), v[31:24]});
            v = v << 8;
        end
    endtask

    task automatic random_pairs(input logic s);
        for (int p = 0; p < 16; p++) begin
            a_v[p] = 16'($urandom_range(0, 65535));
            b_v[p] = 16'($urandom_range(0, 65535));
            p_v[p] = ref_prod(a_v[p], b_v[p], s);
        end
    endtask

    task automatic run0(input logic s, input int want_edges, input string name);
        int n;
        bit seen;
        @(negedge clk);
        sm0 = s; start0 = 1'b0;
        seen = 0;
        for (n = 1; n <= 1000; n++) begin
            @(posedge clk);
            #1;
            if (done0) begin seen = 1; break; end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_done_edges"}, 32'(n), 32'(want_edges));
        check({name, "_busy_low"}, 32'(busy0), 32'd0);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_dst0(input string name);
        for (int p = 0; p < 16; p++)
            check(name, {mem0[64+4*p], mem0[65+4*p], mem0[66+4*p], mem0[67+4*p]}, p_v[p]);
    endtask

    task automatic release_start();
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1;
        check("done_low_after_start", 32'(done0), 32'd0);
    endtask

    initial begin
        logic seen_done;
        tv[0] = '{16'h0003, 16'hFFFB, 1'b1, 32'hFFFFFFF1};
        tv[1] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
        tv[2] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};
        tv[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
        tv[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
        tv[5] = '{16'h0000, 16'h1234, 1'b0, 32'h00000000};
        tv[6] = '{16'h1234, 16'h0001, 1'b1, 32'h00001234};
        tv[7] = '{16'h00FF, 16'h0100, 1'b0, 32'h0000FF00};

        rst_n = 1'b0; start0 = 1'b1; start1 = 1'b1; sm0 = 1'b0; sm1 = 1'b1;
        f0_en = 1'b0; f1_en = 1'b0; f0_addr = '0; f0_data = '0; f1_addr = '0; f1_data = '0;
        #3;
        check("rst_done", 32'(done0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_wr_en", 32'(wr0), 32'd0);
        check("rst_addr", 32'(addr0), 32'd0);
        check("rst_wdata", 32'(wdata0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, one run per mode; leftover pairs are random.
        for (int m = 1; m >= 0; m--) begin
            int p;
            p = 0;
            random_pairs(1'(m));
            for (int i = 0; i < 8; i++) begin
                if (tv[i].s == 1'(m)) begin
                    a_v[p] = tv[i].a; b_v[p] = tv[i].b; p_v[p] = tv[i].p;
                    tv_pair[i] = p;
                    p++;
                end
            end
            fill_src0();
            clear_dst0();
            for (int q = 0; q < 16; q++) push_pair(q, 4);
            run0(1'(m), 401, m ? "table_signed" : "table_unsigned");
            for (int i = 0; i < 8; i++) begin
                if (tv[i].s == 1'(m)) begin
                    int q;
                    q = tv_pair[i];
                    check($sformatf("table_vec%0d", i),
                          {mem0[64+4*q], mem0[65+4*q], mem0[66+4*q], mem0[67+4*q]}, tv[i].p);
                end
            end
            release_start();
        end

        // Random run twice with start toggled between runs.
        begin
            logic s;
            s = 1'($urandom_range(0, 1));
            random_pairs(s);
            fill_src0();
            clear_dst0();
            for (int q = 0; q < 16; q++) push_pair(q, 4);
            run0(s, 401, "rand_run1");
            check_dst0("rand_run1_dst");
            release_start();
            clear_dst0();
            for (int q = 0; q < 16; q++) push_pair(q, 4);
            run0(s, 401, "rand_run2");
            check_dst0("rand_run2_dst");
            release_start();
        end

        // Abort with start=1 during pair 5's MUL.
        random_pairs(1'b1);
        fill_src0();
        clear_dst0();
        for (int q = 0; q < 5; q++) push_pair(q, 4);
        @(negedge clk);
        sm0 = 1'b1; start0 = 1'b0;
        repeat (135) @(posedge clk);
        #1 start0 = 1'b1;
        seen_done = 1'b0;
        repeat (450) begin
            @(posedge clk); #1;
            if (done0) seen_done = 1'b1;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        check("abort_busy_low", 32'(busy0), 32'd0);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        for (int p = 0; p < 5; p++)
            check("abort_written", {mem0[64+4*p], mem0[65+4*p], mem0[66+4*p], mem0[67+4*p]}, p_v[p]);
        for (int p = 5; p < 16; p++)
            check("abort_untouched", {mem0[64+4*p], mem0[65+4*p], mem0[66+4*p], mem0[67+4*p]}, 32'hA5A5A5A5);

        // Reset asserted after two bytes of pair 2's STORE.
        random_pairs(1'b0);
        fill_src0();
        clear_dst0();
        push_pair(0, 4);
        push_pair(1, 4);
        push_pair(2, 2);
        @(negedge clk);
        sm0 = 1'b0; start0 = 1'b0;
        repeat (73) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_wr_en", 32'(wr0), 32'd0);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_done", 32'(done0), 32'd0);
        check("midrst_addr", 32'(addr0), 32'd0);
        check("midrst_wdata", 32'(wdata0), 32'd0);
        start0 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        check("midrst_pair2", {mem0[72], mem0[73], mem0[74], mem0[75]},
              {p_v[2][31:16], 16'hA5A5});
        check("midrst_pair3", {mem0[76], mem0[77], mem0[78], mem0[79]}, 32'hA5A5A5A5);

        // Narrow configuration: OP_BYTES=1, two pairs, products at byte 4.
        wr_mem1(0, 8'h80); wr_mem1(1, 8'h80); wr_mem1(2, 8'h07); wr_mem1(3, 8'hFF);
        for (int k = 4; k < 8; k++) wr_mem1(k, 8'hA5);
        begin
            int n;
            bit seen;
            @(negedge clk);
            sm1 = 1'b1; start1 = 1'b0;
            seen = 0;
            for (n = 1; n <= 200; n++) begin
                @(posedge clk); #1;
                if (done1) begin seen = 1; break; end
            end
            check("small_done_seen", 32'(seen), 32'd1);
            check("small_done_edges", 32'(n), 32'd27);
            check("small_p0", {16'b0, mem1[4], mem1[5]}, 32'h00004000);
            check("small_p1", {16'b0, mem1[6], mem1[7]}, 32'h0000FFF9);
            @(negedge clk); start1 = 1'b1;
            @(posedge clk); #1;
            check("small_done_clear", 32'(done1), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
